if_fetch_unit: RTL

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC, issues requests to a variable-latency instruction memory, and buffers one fetched instruction with its PC+4 for IF/ID to latch. It honours the hazard-unit `hold` and handles branch/jump redirects from ID, including dropping wrong-path responses that are still in flight. When no valid instruction is available it presents a NOP (`32'b0`), so IF/ID latches a bubble.

---
 rtl/if_fetch_unit_pkg.sv | 18 +
 rtl/if_fetch_unit_fetch_buffer.sv | 40 ++++
 rtl/if_fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch stage
package if_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// rtl/if_fetch_unit_fetch_buffer.sv - one-entry instruction/PC holding buffer
module if_fetch_unit_fetch_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_consume,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // Flush beats load, load beats consume: a load on a consume edge refills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= 32'h0;
            r_pc    <= 32'h0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, memory requests, redirect and wrong-path drop
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out,
    output logic        fetch_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_drop_addr;
    logic [31:0]  w_drop_addr_nxt;
    logic         r_req_active;
    logic         w_req_active_nxt;

    logic         w_req;
    logic [31:0]  w_addr;
    logic         w_load;
    logic         w_consume;
    logic         w_can_accept;
    logic [31:0]  w_redirect_target;
    logic         w_buf_valid;
    logic [31:0]  w_buf_instr;
    logic [31:0]  w_buf_pc;

    assign w_redirect_target = word_align(redirect_pc);
    assign w_consume         = w_buf_valid && !hold;
    assign w_can_accept      = !w_buf_valid || !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_drop_addr  <= RESET_PC;
            r_req_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop_addr  <= w_drop_addr_nxt;
            r_req_active <= w_req_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drop_addr_nxt  = r_drop_addr;
        w_req_active_nxt = r_req_active;
        w_load           = 1'b0;
        w_req            = 1'b0;
        w_addr           = r_pc;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_REQ;
                if (redirect_en) begin
                    w_pc_nxt = w_redirect_target;
                end
            end
            S_REQ: begin
                w_req = r_req_active || w_can_accept;
                if (redirect_en) begin
                    w_pc_nxt         = w_redirect_target;
                    w_req_active_nxt = 1'b0;
                    // An unanswered request cannot be withdrawn; park it and swallow its data.
                    if (w_req && !imem_ready) begin
                        w_drop_addr_nxt = r_pc;
                        w_state_nxt     = S_DROP;
                    end
                end else if (w_req && imem_ready) begin
                    w_load           = 1'b1;
                    w_pc_nxt         = r_pc + INSTR_BYTES;
                    w_req_active_nxt = 1'b0;
                end else if (w_req) begin
                    w_req_active_nxt = 1'b1;
                end
            end
            S_DROP: begin
                w_req  = 1'b1;
                w_addr = r_drop_addr;
                if (redirect_en) begin
                    w_pc_nxt = w_redirect_target;
                end
                if (imem_ready) begin
                    w_state_nxt      = S_REQ;
                    w_req_active_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    if_fetch_unit_fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_consume (w_consume),
        .i_flush   (redirect_en),
        .i_instr   (imem_rdata),
        .i_pc      (r_pc),
        .o_valid   (w_buf_valid),
        .o_instr   (w_buf_instr),
        .o_pc      (w_buf_pc)
    );

    assign imem_req     = w_req;
    assign imem_addr    = w_addr;
    assign fetch_valid  = w_buf_valid;
    assign instr_out    = w_buf_valid ? w_buf_instr : NOP_INSTR;
    assign pc_plus4_out = (w_buf_valid ? w_buf_pc : r_pc) + INSTR_BYTES;

endmodule
